// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (port 0) and a DMA/loader master (port 1).
// Latency: gnt is combinational in IDLE, memory is driven in the following ACCESS cycle, and ack/err plus rdata are registered one cycle after that.
// Backpressure: one access every two cycles; requests seen during ACCESS are ignored. Define ARB_FIXED_PRIO_EN to make port 0 always win.
module dmem_arbiter #(
  parameter int          RAM_SIZE_BIT = 9,
  parameter logic [31:0] LED_ADDR     = 32'h4000000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic        owner;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        any_req;
  logic        win1;
  logic        legal;

  assign any_req = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
  // Port 0 takes every tie; port 1 only wins when it is the sole requester.
  assign win1 = req1 & ~req0;
`else
  // ptr == 1 means port 1 is favoured on the next tie.
  logic ptr;
  assign win1 = req1 & (~req0 | ptr);

  // After each grant the pointer favours the port that did not win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= 1'b0;
    else if (state == IDLE && any_req)
      ptr <= ~win1;
  end
`endif

  // Only word-aligned RAM addresses or the LED register reach memory.
  assign legal = (lat_addr[1:0] == 2'b00) &&
                 ((lat_addr[31:RAM_SIZE_BIT+2] == '0) || (lat_addr == LED_ADDR));

  // State register; async reset drops an in-flight access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state, grants and memory pins; memory pins stay quiet outside ACCESS.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt0      = ~win1;
          gnt1      = win1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_read  = legal & ~lat_we;
        mem_write = legal & lat_we;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winning request on the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else if (state == IDLE && any_req) begin
      owner     <= win1;
      lat_we    <= win1 ? we1    : we0;
      lat_addr  <= win1 ? addr1  : addr0;
      lat_wdata <= win1 ? wdata1 : wdata0;
    end
  end

  // Completion: one-cycle ack or err to the owner; rdata held until that port's next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= 32'h0;
      rdata1 <= 32'h0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      if (state == ACCESS) begin
        if (owner) begin
          ack1   <= legal;
          err1   <= ~legal;
          rdata1 <= (legal && !lat_we) ? mem_rdata : 32'h0;
        end else begin
          ack0   <= legal;
          err0   <= ~legal;
          rdata0 <= (legal && !lat_we) ? mem_rdata : 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
// Latency: checks are made 1 time unit after each rising edge, covering cycles N, N+1 and N+2 of every access.
// Backpressure: exercises contention, back-to-back grants and a reset that lands in the ACCESS cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;
  logic        gnt0, gnt1, ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram [0:511];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Combinational read, write committed on the rising edge; LED address is not stored.
  assign mem_rdata = ram[mem_addr[10:2]];

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    ram[0] = 32'h756e696c;
    forever begin
      @(posedge clk);
      if (mem_write && mem_addr[31:11] == 21'h0)
        ram[mem_addr[10:2]] = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One uncontended access by port p; caller is 1 unit after an edge with the DUT in IDLE.
  task automatic do_access(input string tag, input bit p, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit legal, input logic [31:0] exp_rd);
    if (p) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else   begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    #1;
    check({tag, "_gnt"},      32'(p ? gnt1 : gnt0), 32'd1);
    check({tag, "_gnt_oth"},  32'(p ? gnt0 : gnt1), 32'd0);
    check({tag, "_idle_rd"},  32'(mem_read), 32'd0);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    check({tag, "_acc_gnt"},  32'(gnt0 | gnt1), 32'd0);
    check({tag, "_mem_rd"},   32'(mem_read),  32'(legal & !we));
    check({tag, "_mem_wr"},   32'(mem_write), 32'(legal & we));
    check({tag, "_mem_addr"}, mem_addr, addr);
    if (we) check({tag, "_mem_wdata"}, mem_wdata, wdata);
    tick();
    check({tag, "_ack"},      32'(p ? ack1 : ack0), 32'(legal));
    check({tag, "_err"},      32'(p ? err1 : err0), 32'(!legal));
    check({tag, "_ack_oth"},  32'(p ? ack0 : ack1), 32'd0);
    check({tag, "_rdata"},    p ? rdata1 : rdata0, (legal && !we) ? exp_rd : 32'h0);
    check({tag, "_idle_mem"}, mem_addr, 32'h0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    #2;
    check("rst_gnt",   32'({gnt0, gnt1}), 32'd0);
    check("rst_ack",   32'({ack0, ack1, err0, err1}), 32'd0);
    check("rst_rdata", rdata0 | rdata1, 32'h0);
    check("rst_mem",   32'({mem_read, mem_write}), 32'd0);
    check("rst_maddr", mem_addr | mem_wdata, 32'h0);
    apply_reset();

    // Basic read, write-then-read, illegal addresses, LED passthrough
    do_access("rd0",     1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h756e696c);
    do_access("wr1",     1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF,  1'b1, 32'h0);
    do_access("rd1",     1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEADBEEF);
    check("rd0_hold", rdata0, 32'h756e696c);
    do_access("ill802",  1'b0, 1'b0, 32'h0000_0802, 32'h0,         1'b0, 32'h0);
    do_access("ill800",  1'b0, 1'b1, 32'h0000_0800, 32'h1234_5678, 1'b0, 32'h0);
    do_access("led",     1'b0, 1'b1, 32'h4000_000C, 32'h0000_0003, 1'b1, 32'h0);
    check("ill_nowr", ram[0], 32'h756e696c);

    // Contention from reset: both held high, grants on cycles 0,2,4,6
    apply_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c % 2 == 0) begin
`ifdef ARB_FIXED_PRIO_EN
        check($sformatf("cont_gnt0_c%0d", c), 32'(gnt0), 32'd1);
        check($sformatf("cont_gnt1_c%0d", c), 32'(gnt1), 32'd0);
`else
        check($sformatf("cont_gnt0_c%0d", c), 32'(gnt0), 32'((c / 2) % 2 == 0));
        check($sformatf("cont_gnt1_c%0d", c), 32'(gnt1), 32'((c / 2) % 2 == 1));
`endif
      end else begin
        check($sformatf("cont_nogn_c%0d", c), 32'(gnt0 | gnt1), 32'd0);
      end
      if (c == 7) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
    end
`ifdef ARB_FIXED_PRIO_EN
    check("cont_last_ack", 32'({ack0, ack1}), 32'b10);
`else
    check("cont_last_ack", 32'({ack0, ack1}), 32'b01);
    check("cont_rdata1",   rdata1, 32'hDEADBEEF);
`endif

    // Reset mid-access: port 0 write to 0x30 aborted; pointer would favour port 1 without the reset
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h55;
    #1;
    check("mid_gnt0", 32'(gnt0), 32'd1);
    tick();
    req0 = 1'b0;
    #1;
    check("mid_wr_pre", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_wr_drop", 32'(mem_write), 32'd0);
    tick();
    check("mid_noack", 32'({ack0, ack1, err0, err1}), 32'd0);
    reset = 1'b0;
    tick();
    check("mid_noack2", 32'({ack0, ack1, err0, err1}), 32'd0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
    #1;
    check("post_gnt0", 32'(gnt0), 32'd1);
    check("post_gnt1", 32'(gnt1), 32'd0);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("post_ack0",  32'(ack0), 32'd1);
    check("post_rdata", rdata0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
